// File: rtl/vram_write_scheduler.sv
// vram_write_scheduler
//   Buffers CPU writes to VRAM in an in-order FIFO and replays them into the
//   VRAM write port only while the drain window is open, so CPU writes never
//   collide with active-video reads.
//
//   Default window: ~(hvisible & vvisible), so draining happens in any blanking.
//   Optional macro VRAM_WRITE_VBLANK_ONLY_EN: window becomes ~vvisible, so
//   draining happens only in vertical blanking.
//
// Parameters
//   FIFO_DEPTH      number of buffered writes (power of two, 2..32)
//   VRAM_ADDR_WIDTH VRAM address width
// Ports
//   clk, rst            pixel clock, asynchronous active-high reset
//   cpu_data/address    CPU write payload
//   cpu_cs              write strobe, sampled every rising clk edge
//   hvisible, vvisible  visible-area flags from the GPU counters
//   ovf_clr             synchronous clear of the overflow flag
//   vram_we/waddr/wdata VRAM write port (address/data come from FIFO head)
//   cpu_ready           FIFO not full
//   fifo_level          current FIFO occupancy
//   overflow            sticky flag: a write was dropped
module vram_write_scheduler #(
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned VRAM_ADDR_WIDTH = 13
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     cpu_data,
  input  logic [VRAM_ADDR_WIDTH-1:0]     cpu_address,
  input  logic                           cpu_cs,
  input  logic                           hvisible,
  input  logic                           vvisible,
  input  logic                           ovf_clr,
  output logic                           vram_we,
  output logic [VRAM_ADDR_WIDTH-1:0]     vram_waddr,
  output logic [7:0]                     vram_wdata,
  output logic                           cpu_ready,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned EW = VRAM_ADDR_WIDTH + 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            window;
  logic            full;
  logic            push;
  logic            pop;
  logic            drop;
  logic [LW-1:0]   level_next;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [EW-1:0]   mem [FIFO_DEPTH];

`ifdef VRAM_WRITE_VBLANK_ONLY_EN
  assign window = ~vvisible;
`else
  assign window = ~(hvisible & vvisible);
`endif

  assign full      = (fifo_level == LW'(FIFO_DEPTH));
  assign cpu_ready = ~full;
  assign pop       = vram_we;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign push      = cpu_cs & (~full | pop);
  assign drop      = cpu_cs & full & ~pop;

  always_comb begin
    level_next = fifo_level;
    case ({push, pop})
      2'b10:   level_next = fifo_level + LW'(1);
      2'b01:   level_next = fifo_level - LW'(1);
      default: level_next = fifo_level;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next state from post-update occupancy and the window at this edge
  always_comb begin
    state_next = ST_IDLE;
    if (level_next == '0) begin
      state_next = ST_IDLE;
    end else if (window) begin
      state_next = ST_DRAIN;
    end else begin
      state_next = ST_WAIT;
    end
  end

  // FSM: outputs. Gating with the live window drops vram_we the moment the
  // window closes, even though the state only catches up on the next edge.
  always_comb begin
    vram_we = (state == ST_DRAIN) & window;
  end

  // FIFO bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      fifo_level <= level_next;
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Storage needs no reset: contents are only observed while vram_we=1.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cpu_address, cpu_data};
    end
  end

  always_comb begin
    {vram_waddr, vram_wdata} = mem[rd_ptr];
  end

endmodule
